// File: rtl/prod_burst_gen.sv
// prod_burst_gen: pseudo-random burst traffic producer with a val/rdy handshake.
//
// Emits bursts of valid beats separated by idle gaps. Burst length, gap length
// and random data are drawn from a 16-bit Galois LFSR (mask 16'hB400) that
// advances on every non-reset cycle. All draws in a cycle use the LFSR value
// held in that cycle, before it advances.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   en         in   permits a new burst to start (never truncates a burst)
//   mode       in   data mode sampled at burst start:
//                   0 random, 1 incrementing, 2 burst index, 3 same as 0
//   rdy        in   consumer ready; a beat transfers when val && rdy
//   val        out  beat valid
//   data       out  beat data (DATA_W bits)
//   last       out  final beat of the burst, qualified by val
//   burst_cnt  out  number of completed bursts, wraps at 2^CNT_W
module prod_burst_gen #(
    parameter int          DATA_W    = 8,
    parameter int          MIN_VALID = 3,
    parameter int          MAX_VALID = 5,
    parameter int          MIN_IDLE  = 1,
    parameter int          MAX_IDLE  = 4,
    parameter int          DATA_MAX  = 5,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              rdy,
    output logic              val,
    output logic [DATA_W-1:0] data,
    output logic              last,
    output logic [CNT_W-1:0]  burst_cnt
);

    localparam int          V_SPAN    = MAX_VALID - MIN_VALID + 1;
    localparam int          I_SPAN    = MAX_IDLE - MIN_IDLE + 1;
    localparam int          BL_W      = $clog2(MAX_VALID + 1);
    localparam int          GAP_W     = $clog2(MAX_IDLE + 1);
    // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic {
        ST_GAP,
        ST_BURST
    } state_t;

    state_t             state_q,      state_d;
    logic               val_q,        val_d;
    logic               last_q,       last_d;
    logic [DATA_W-1:0]  data_q,       data_d;
    logic [CNT_W-1:0]   burst_cnt_q,  burst_cnt_d;
    logic [DATA_W-1:0]  seq_q,        seq_d;
    logic [1:0]         mode_q,       mode_d;
    logic [GAP_W-1:0]   gap_cnt_q,    gap_cnt_d;
    logic [BL_W-1:0]    beats_left_q, beats_left_d;
    logic [15:0]        lfsr_q,       lfsr_d;

    logic [BL_W-1:0]    len_draw;
    logic [GAP_W-1:0]   gap_draw;
    logic [1:0]         mode_eff;

    // Length uses the high LFSR byte and gap the low byte, so the two draws
    // taken from the same LFSR value are not trivially correlated.
    assign len_draw = BL_W'(MIN_VALID + (int'(lfsr_q[15:8]) % V_SPAN));
    assign gap_draw = GAP_W'(MIN_IDLE + (int'(lfsr_q[7:0]) % I_SPAN));
    assign mode_eff = (mode == 2'd3) ? 2'd0 : mode;

    function automatic logic [DATA_W-1:0] beat_value(
        input logic [1:0]        m,
        input logic [15:0]       l,
        input logic [DATA_W-1:0] seq_val,
        input logic [CNT_W-1:0]  cnt
    );
        case (m)
            2'd1:    beat_value = seq_val;
            2'd2:    beat_value = DATA_W'(cnt);
            default: beat_value = DATA_W'(int'(l) % (DATA_MAX + 1));
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        val_d        = val_q;
        last_d       = last_q;
        data_d       = data_q;
        burst_cnt_d  = burst_cnt_q;
        seq_d        = seq_q;
        mode_d       = mode_q;
        gap_cnt_d    = gap_cnt_q;
        beats_left_d = beats_left_q;
        lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

        case (state_q)
            ST_GAP: begin
                // gap_cnt counts down to 1 and parks there until en allows
                // the next burst; the start edge is the last low cycle.
                if ((gap_cnt_q == GAP_W'(1)) && en) begin
                    beats_left_d = len_draw;
                    val_d        = 1'b1;
                    last_d       = (len_draw == BL_W'(1));
                    mode_d       = mode_eff;
                    data_d       = beat_value(mode_eff, lfsr_q, seq_q, burst_cnt_q);
                    state_d      = ST_BURST;
                end else if (gap_cnt_q > GAP_W'(1)) begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            ST_BURST: begin
                // Without a transfer nothing changes, so the beat is held
                // stable under backpressure.
                if (val_q && rdy) begin
                    if (mode_q == 2'd1) begin
                        seq_d = seq_q + DATA_W'(1);
                    end
                    if (beats_left_q > BL_W'(1)) begin
                        beats_left_d = beats_left_q - BL_W'(1);
                        data_d       = beat_value(mode_q, lfsr_q, seq_d, burst_cnt_q);
                        last_d       = (beats_left_q == BL_W'(2));
                    end else begin
                        beats_left_d = '0;
                        val_d        = 1'b0;
                        last_d       = 1'b0;
                        burst_cnt_d  = burst_cnt_q + CNT_W'(1);
                        gap_cnt_d    = gap_draw;
                        state_d      = ST_GAP;
                    end
                end
            end
            default: state_d = ST_GAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_GAP;
            val_q        <= 1'b0;
            last_q       <= 1'b0;
            data_q       <= '0;
            burst_cnt_q  <= '0;
            seq_q        <= '0;
            mode_q       <= 2'd0;
            gap_cnt_q    <= GAP_W'(MIN_IDLE);
            beats_left_q <= '0;
            lfsr_q       <= SEED_EFF;
        end else begin
            state_q      <= state_d;
            val_q        <= val_d;
            last_q       <= last_d;
            data_q       <= data_d;
            burst_cnt_q  <= burst_cnt_d;
            seq_q        <= seq_d;
            mode_q       <= mode_d;
            gap_cnt_q    <= gap_cnt_d;
            beats_left_q <= beats_left_d;
            lfsr_q       <= lfsr_d;
        end
    end

    assign val       = val_q;
    assign last      = last_q;
    assign data      = data_q;
    assign burst_cnt = burst_cnt_q;

endmodule

// File: doc/prod_burst_gen.md
Name: prod_burst_gen

Overview:
Parametrised, synthesizable burst traffic producer for bench and on-chip stimulus. Emits bursts of valid beats separated by idle gaps; burst and gap lengths are pseudo-random within parameter bounds. Adds a val/rdy handshake with backpressure, selectable data modes, an end-of-burst marker and a completed-burst counter. Sits upstream of any consumer block using the val/rdy protocol.

Parameters:
DATA_W, 8, data bus width (1..32)
MIN_VALID, 3, minimum beats per burst (>=1)
MAX_VALID, 5, maximum beats per burst (>=MIN_VALID)
MIN_IDLE, 1, minimum idle cycles between bursts (>=1)
MAX_IDLE, 4, maximum idle cycles between bursts (>=MIN_IDLE)
DATA_MAX, 5, upper bound of random data (inclusive)
SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001
CNT_W, 16, width of burst_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
en  in  1  permit new bursts to start
mode  in  2  data mode, sampled at burst start: 0 random, 1 incrementing, 2 burst index, 3 treated as 0
rdy  in  1  consumer ready
val  out  1  data valid
data  out  DATA_W  beat data
last  out  1  high on final beat of burst, qualified by val
burst_cnt  out  CNT_W  completed bursts, wraps at 2^CNT_W

Behaviour:
- Reset (rst=1 at rising edge): val=0, last=0, data=0, burst_cnt=0, seq counter=0, LFSR=SEED, state=GAP, gap_cnt=MIN_IDLE, beats_left=0. Reset wins over all other events, including mid-burst and mid-stall.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), advances every non-reset cycle. All draws use the pre-advance value L.
- Draws: burst length = MIN_VALID + (L[15:8] mod (MAX_VALID-MIN_VALID+1)); gap = MIN_IDLE + (L[7:0] mod (MAX_IDLE-MIN_IDLE+1)); random data = L mod (DATA_MAX+1), truncated to DATA_W.
- Data by mode: 0 random draw; 1 seq counter value (counter increments on each accepted beat in mode 1, wraps at 2^DATA_W); 2 burst_cnt[DATA_W-1:0], constant for the burst. Mode latched at burst start, held for the whole burst.
- Transfer = val && rdy at rising edge.
- State GAP (val=0): if gap_cnt==1 and en: draw length N, beats_left<=N, val<=1, present first beat, last<=(N==1), go BURST. Else if gap_cnt>1: gap_cnt--. If gap_cnt==1 and !en: hold.
- Consequence: val low exactly G cycles between bursts when en=1; after reset release, first val rises after MIN_IDLE cycles.
- State BURST (val=1): without transfer, data/last/val hold stable (no change while stalled). On transfer with beats_left>1: beats_left--, next beat, last<=(beats_left==2). On transfer with beats_left==1: val<=0, last<=0, burst_cnt++, gap_cnt<=drawn gap, go GAP.
- en deassertion never truncates a burst in progress; it only blocks the next start.
- burst_cnt increments on the cycle after the last beat's transfer edge; wraps silently.
- Valid beats per burst always in [MIN_VALID, MAX_VALID]; gap always in [MIN_IDLE, MAX_IDLE].

Test Plan:
- MIN_VALID=MAX_VALID=3, MIN_IDLE=MAX_IDLE=2, mode=1, rdy=1, en=1 -> after reset val low 2 cycles, then data 0,1,2 with last on 2, val low 2 cycles, then 3,4,5; burst_cnt=2 after second burst.
- Same config, rdy low for 4 cycles on second beat -> val, data=1, last=0 held stable all 4 cycles; burst still 3 transfers; gap still exactly 2 cycles after last transfer.
- Default params, mode=0, rdy random 50%, 1000 cycles -> every burst 3..5 transfers, every gap 1..4 cycles, all data <=5, exactly one last per burst, burst_cnt equals counted bursts.
- mode=2, fixed lengths 2/1 -> bursts carry data 0,0 then 1,1 then 2,2; mode changed mid-burst to 1 -> current burst unchanged.
- en dropped mid-burst -> burst completes with last, val stays 0 while en=0; en reasserted -> next burst starts the following cycle if gap already expired.
- rst asserted during a stalled beat -> next cycle val=0, last=0, burst_cnt=0, data=0; restart sequence identical to post-power-up sequence (same SEED).
